// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
// Optional DIV8_DBZ_EN adds a registered divide-by-zero flag and forces quot=0 when it is set.
module div8_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
`ifdef DIV8_DBZ_EN
    ,
    output logic             dbz
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   r_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [WIDTH:0]     r_shift;
    logic               r_ge;
    logic               accept;

    // The partial remainder is always < divisor after a step, so only the
    // shifted value needs the extra bit for the compare/subtract.
    assign r_shift = {r_reg, q_reg[WIDTH-1]};
    assign r_ge    = (r_shift >= {1'b0, d_reg});
    assign accept  = (state_reg == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt_reg == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            d_reg   <= '0;
        end else if (accept) begin
            cnt_reg <= CNT_W'(WIDTH - 1);
            q_reg   <= dividend;
            r_reg   <= '0;
            d_reg   <= divisor;
        end else if (state_reg == CALC) begin
            cnt_reg <= cnt_reg - 1'b1;
            q_reg   <= {q_reg[WIDTH-2:0], r_ge};
            r_reg   <= r_ge ? WIDTH'(r_shift - {1'b0, d_reg}) : r_shift[WIDTH-1:0];
        end
    end

`ifdef DIV8_DBZ_EN
    logic dbz_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_reg <= 1'b0;
        end else if (accept) begin
            dbz_reg <= (divisor == '0);
        end
    end

    // With a zero divisor the recurrence already leaves rem=dividend; only quot is overridden.
    assign dbz  = dbz_reg;
    assign quot = dbz_reg ? '0 : q_reg;
    assign rem  = r_reg;
`else
    assign quot = q_reg;
    assign rem  = r_reg;
`endif

endmodule

// File: tb/tb_div8_seq.sv
// Directed and swept checks for div8_seq: reset, latency, boundaries, divide-by-zero,
// backpressure, reset during calculation and back-to-back throughput.
module tb_div8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       dbz_o;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div8_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem)
`ifdef DIV8_DBZ_EN
        ,
        .dbz       (dbz_o)
`endif
    );

`ifndef DIV8_DBZ_EN
    assign dbz_o = 1'b0;
`endif

    // Drives one operand pair, returns the result and the cycle count from the
    // accept cycle to the first cycle showing out_valid (accept cycle = 0).
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int stall,
                           output logic [7:0] q, output logic [7:0] r, output logic d,
                           output int lat, output bit timeout);
        int n;
        timeout = 1'b0;
        q = 8'd0; r = 8'd0; d = 1'b0; lat = 0;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            timeout = 1'b1;
            return;
        end
        in_valid = 1'b1; dividend = a; divisor = b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            timeout = 1'b1;
            return;
        end
        q = quot; r = rem; d = dbz_o;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("div %0d/%0d -> quot=%0d rem=%0d dbz=%0d lat=%0d", a, b, q, r, d, lat);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (quot !== 8'd0 || rem !== 8'd0 || dbz_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: quot=%0d rem=%0d dbz=%b required 0/0/0", quot, rem, dbz_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] q, r; logic d; int lat; bit to;
        run_div(8'd100, 8'd7, 0, q, r, d, lat, to);
        checks++;
        if (to || q !== 8'd14 || r !== 8'd2) begin
            errors++;
            $display("FAIL basic_100_7: quot=%0d rem=%0d timeout=%0d required 14/2", q, r, to);
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL latency: got %0d cycles required 9", lat);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] q, r; logic d; int lat; bit to;
        run_div(8'd255, 8'd1, 0, q, r, d, lat, to);
        checks++;
        if (to || q !== 8'd255 || r !== 8'd0) begin
            errors++;
            $display("FAIL bound_255_1: quot=%0d rem=%0d required 255/0", q, r);
        end
        run_div(8'd0, 8'd255, 1, q, r, d, lat, to);
        checks++;
        if (to || q !== 8'd0 || r !== 8'd0) begin
            errors++;
            $display("FAIL bound_0_255: quot=%0d rem=%0d required 0/0", q, r);
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic d; int lat; bit to;
        run_div(8'd37, 8'd0, 0, q, r, d, lat, to);
`ifdef DIV8_DBZ_EN
        checks++;
        if (to || q !== 8'd0 || r !== 8'd37 || d !== 1'b1) begin
            errors++;
            $display("FAIL dbz_37_0: quot=%0d rem=%0d dbz=%b required 0/37/1", q, r, d);
        end
`else
        checks++;
        if (to || q !== 8'd255 || r !== 8'd37) begin
            errors++;
            $display("FAIL dbz_37_0: quot=%0d rem=%0d required 255/37", q, r);
        end
`endif
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL dbz_latency: got %0d cycles required 9", lat);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q, r; logic d; int lat; bit to;
        int n;
        out_ready = 1'b0;
        in_valid = 1'b1; dividend = 8'd200; divisor = 8'd13;
        @(posedge clk); #1;
        dividend = 8'd50; divisor = 8'd5;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== 8'd15 || rem !== 8'd5) begin
                errors++;
                $display("FAIL hold_cycle%0d: ov=%b ir=%b quot=%0d rem=%0d required 1/0/15/5",
                         i, out_valid, in_ready, quot, rem);
            end
            @(posedge clk); #1;
        end
        $display("div 200/13 held 20 cycles -> quot=%0d rem=%0d", quot, rem);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_hs: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        in_valid = 1'b0;
        run_div(8'd50, 8'd5, 0, q, r, d, lat, to);
        checks++;
        if (to || q !== 8'd10 || r !== 8'd0) begin
            errors++;
            $display("FAIL after_hold_50_5: quot=%0d rem=%0d required 10/0", q, r);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [7:0] q, r; logic d; int lat; bit to;
        in_valid = 1'b1; dividend = 8'd250; divisor = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quot !== 8'd0 || rem !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: ov=%b ir=%b quot=%0d rem=%0d required 0/1/0/0",
                     out_valid, in_ready, quot, rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_div(8'd9, 8'd2, 0, q, r, d, lat, to);
        checks++;
        if (to || q !== 8'd4 || r !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_9_2: quot=%0d rem=%0d required 4/1", q, r);
        end
    endtask

    task automatic test_back_to_back();
        int t0, n;
        out_ready = 1'b1;
        in_valid = 1'b1; dividend = 8'd100; divisor = 8'd7;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        t0 = cyc;
        @(posedge clk); #1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc - t0 !== 10) begin
            errors++;
            $display("FAIL throughput: %0d cycles between accepts required 10", cyc - t0);
        end
        $display("back-to-back 100/7 accept spacing %0d cycles", cyc - t0);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_sweep();
        logic [7:0] q, r, eq, er; logic d, ed; int lat; bit to;
        logic [15:0] prod;
        for (int a = 0; a < 256; a += 5) begin
            for (int b = 0; b < 256; b += 7) begin
                run_div(8'(a), 8'(b), $urandom_range(0, 3), q, r, d, lat, to);
                if (b == 0) begin
`ifdef DIV8_DBZ_EN
                    eq = 8'd0; ed = 1'b1;
`else
                    eq = 8'd255; ed = 1'b0;
`endif
                    er = 8'(a);
                end else begin
                    eq = 8'(a / b); er = 8'(a % b); ed = 1'b0;
                end
                checks++;
                if (to || q !== eq || r !== er || d !== ed) begin
                    errors++;
                    $display("FAIL sweep_%0d_%0d: quot=%0d rem=%0d dbz=%b required %0d/%0d/%b",
                             a, b, q, r, d, eq, er, ed);
                end
                if (b != 0) begin
                    prod = 16'(q) * 16'(b);
                    checks++;
                    if (8'(prod[7:0] + r) !== 8'(a) || prod + 16'(r) !== 16'(a) || r >= 8'(b)) begin
                        errors++;
                        $display("FAIL identity_%0d_%0d: q*d+r=%0d rem=%0d required %0d rem<%0d",
                                 a, b, prod + 16'(r), r, a, b);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
